contador_modular: RTL

Parametrised up/down counter: the next-generation counter block for the class designs. It generalises the fixed 4-bit up/down counter with load and enable to any width and modulus. It adds a cycle prescaler, a choice of wrap or saturate at the bounds, and registered overflow/underflow pulses. It is intended as the shared counting primitive for timers, dividers and display sequencers.

---
 rtl/contador_pkg.sv | 21 ++
 rtl/contador_prescaler.sv | 44 ++++
 rtl/contador_modular.sv | 109 ++++++++++
 3 files changed

// File: rtl/contador_pkg.sv
// Shared types and helpers for the contador_modular counter family.
//   mode_e    : selects whether a step at a bound wraps or saturates.
//   max_count : largest reachable count for a given width and modulus.
//               The modulus minus one is clamped so it never exceeds
//               2**WIDTH-1.
package contador_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  function automatic int unsigned max_count(input int unsigned width,
                                            input int unsigned modulus);
    int unsigned full;
    full = (32'd1 << width) - 32'd1;
    if (modulus == 0) return 0;
    return ((modulus - 1) > full) ? full : (modulus - 1);
  endfunction

endpackage

// File: rtl/contador_prescaler.sv
// Cycle prescaler: it produces one tick every PRESCALE enabled cycles.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears the partial count
//   clr  : synchronous clear, discards the partial count
//   en   : advance enable
//   tick : high on the enabled cycle that completes a prescale period
// With PRESCALE=1 there is no state, and tick is en passed straight through.
module contador_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  if (PRESCALE <= 1) begin : g_bypass
    // clk, rst and clr are not needed when every enabled cycle is a tick.
    logic unused_inputs;
    assign unused_inputs = clk ^ rst ^ clr;
    assign tick = en;
  end else begin : g_count
    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments, so every
    // register in the design samples its pre-edge values.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (clr) begin
        cnt <= '0;
      end else if (en) begin
        cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/contador_modular.sv
// Parametrised up/down counter with load, prescaler and bound handling.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   load     : load data_in (clamped to MOD-1) on the next edge
//   data_in  : load value
//   con      : count enable (the prescaler advances while it is high)
//   cup      : direction, 1 = up and 0 = down, sampled only when a step fires
//   data_out : registered count, range 0..MOD-1
//   ovf/udf  : registered one-cycle pulses, up-step at MOD-1 / down-step at 0
//   at_max   : data_out == MOD-1
//   at_min   : data_out == 0
// Priority on each edge is rst, then load, then con.
module contador_modular
  import contador_pkg::*;
#(
  parameter int    WIDTH    = 8,
  parameter int    MOD      = 2 ** WIDTH,
  parameter int    PRESCALE = 1,
  parameter mode_e MODE     = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             con,
  input  logic             cup,
  output logic [WIDTH-1:0] data_out,
  output logic             ovf,
  output logic             udf,
  output logic             at_max,
  output logic             at_min
);

  // Comparisons are made one bit wider than the count. This lets a
  // modulus of 2**WIDTH be represented, and it stops a narrower modulus
  // from wrapping silently.
  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(max_count(WIDTH, MOD));
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_V = MAX_X[WIDTH-1:0];
  localparam logic [WIDTH:0]   ONE_X = (WIDTH+1)'(1);

  logic             tick;
  logic [WIDTH:0]   count_x;
  logic [WIDTH:0]   data_in_x;
  logic [WIDTH:0]   inc_x;
  logic [WIDTH:0]   dec_x;
  logic [WIDTH-1:0] next_count;
  logic             next_ovf;
  logic             next_udf;

  // A load discards any partial prescale and blocks the step on that cycle.
  contador_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .en   (con && !load),
    .tick (tick)
  );

  assign count_x   = {1'b0, data_out};
  assign data_in_x = {1'b0, data_in};
  assign inc_x     = count_x + ONE_X;
  assign dec_x     = count_x - ONE_X;

  assign at_max = (count_x == MAX_X);
  assign at_min = (data_out == '0);

  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch can be inferred.
  always_comb begin
    next_count = data_out;
    next_ovf   = 1'b0;
    next_udf   = 1'b0;
    if (load) begin
      next_count = (data_in_x >= MOD_X) ? MAX_V : data_in;
    end else if (tick) begin
      if (cup) begin
        if (count_x >= MAX_X) begin
          next_ovf   = 1'b1;
          next_count = (MODE == MODE_SAT) ? data_out : '0;
        end else begin
          next_count = inc_x[WIDTH-1:0];
        end
      end else begin
        if (count_x == '0) begin
          next_udf   = 1'b1;
          next_count = (MODE == MODE_SAT) ? data_out : MAX_V;
        end else begin
          next_count = dec_x[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      data_out <= next_count;
      ovf      <= next_ovf;
      udf      <= next_udf;
    end
  end

endmodule
